// File: rtl/mram_pkg.sv
// mram_pkg: shared state type, latency bounds and parity helper for the
// dual-port move/position RAM.
package mram_pkg;

    typedef enum logic {
        MRAM_CLEAR = 1'b0,
        MRAM_READY = 1'b1
    } mram_state_e;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 3;
    localparam int MRAM_WIDTH_MAX   = 512;

    // Even parity: the stored bit makes the total number of ones even.
    function automatic logic even_parity(input logic [MRAM_WIDTH_MAX-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mram_rd_pipe.sv
// mram_rd_pipe: read-valid/data shift register that stretches the BRAM output
// to the configured read latency; data stages only load when valid is set.
module mram_rd_pipe
    import mram_pkg::*;
#(
    parameter int WIDTH  = 72,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  dat_q [STAGES];

    always_ff @(posedge clk) begin
        if (flush) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                dat_q[0] <= in_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_data  = dat_q[STAGES-1];

endmodule

// File: rtl/mram_ctrl.sv
// mram_ctrl: read-first dual-port position RAM with selectable read latency,
// clear sequencer and write-collision flag. Define MRAM_PARITY_EN for per-word parity.
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 1024
`endif

// state      | meaning
// MRAM_CLEAR | zeroing one word per cycle, user traffic dropped, busy=1
// MRAM_READY | ports A/B accept reads and writes
module mram_ctrl
    import mram_pkg::*;
#(
    parameter int RAM_WIDTH      = 72,
    parameter int DEPTH          = `MAX_POSITIONS,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int READ_LATENCY   = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear_req,
    output logic                 busy,
    input  logic                 a_en,
    input  logic                 a_wr_en,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [RAM_WIDTH-1:0] a_wr_data,
    output logic [RAM_WIDTH-1:0] a_rd_data,
    output logic                 a_rd_valid,
    input  logic                 b_en,
    input  logic                 b_wr_en,
    input  logic [ADDR_W-1:0]    b_addr,
    input  logic [RAM_WIDTH-1:0] b_wr_data,
    output logic [RAM_WIDTH-1:0] b_rd_data,
    output logic                 b_rd_valid,
    output logic                 collision,
    output logic                 parity_err
);

    localparam int LAT = (READ_LATENCY < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
                         (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY;
`ifdef MRAM_PARITY_EN
    localparam int MW = RAM_WIDTH + 1;
`else
    localparam int MW = RAM_WIDTH;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    mram_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_we, enter_clear;
    logic [MW-1:0]     mem [DEPTH];
    logic [MW-1:0]     a_word, b_word;
    logic              acc_a, acc_b, wr_a, wr_b, rd_a, rd_b, coll_now;
    logic [MW-1:0]     ram_a_q, ram_b_q, a_out, b_out;
    logic              rv_a_q, rv_b_q, a_vld, b_vld;
    logic              coll_q;

`ifdef MRAM_PARITY_EN
    assign a_word = {even_parity(MRAM_WIDTH_MAX'(a_wr_data)), a_wr_data};
    assign b_word = {even_parity(MRAM_WIDTH_MAX'(b_wr_data)), b_wr_data};
`else
    assign a_word = a_wr_data;
    assign b_word = b_wr_data;
`endif

    assign acc_a    = a_en && (state_q == MRAM_READY);
    assign acc_b    = b_en && (state_q == MRAM_READY);
    assign wr_a     = acc_a && a_wr_en;
    assign rd_a     = acc_a && !a_wr_en;
    assign rd_b     = acc_b && !b_wr_en;
    assign coll_now = wr_a && acc_b && b_wr_en && (a_addr == b_addr);
    assign wr_b     = acc_b && b_wr_en && !coll_now;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? MRAM_CLEAR : MRAM_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_we      = 1'b0;
        enter_clear = 1'b0;
        case (state_q)
            MRAM_CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = MRAM_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            MRAM_READY: begin
                if (clear_req) begin
                    state_d     = MRAM_CLEAR;
                    cnt_d       = '0;
                    enter_clear = 1'b1;
                end
            end
            default: state_d = MRAM_READY;
        endcase
    end

    // Array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (clr_we) begin
                mem[cnt_q] <= '0;
            end else begin
                if (wr_a) mem[a_addr] <= a_word;
                if (wr_b) mem[b_addr] <= b_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ram_a_q <= '0;
            ram_b_q <= '0;
            rv_a_q  <= 1'b0;
            rv_b_q  <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            rv_a_q <= rd_a;
            rv_b_q <= rd_b;
            if (rd_a) ram_a_q <= mem[a_addr];
            if (rd_b) ram_b_q <= mem[b_addr];
            if (enter_clear) coll_q <= 1'b0;
            else if (coll_now) coll_q <= 1'b1;
        end
    end

    if (LAT > 1) begin : g_pipe
        mram_rd_pipe #(.WIDTH(MW), .STAGES(LAT - 1)) u_pipe_a (
            .clk(clk), .flush(!reset_n), .in_valid(rv_a_q), .in_data(ram_a_q),
            .out_valid(a_vld), .out_data(a_out)
        );
        mram_rd_pipe #(.WIDTH(MW), .STAGES(LAT - 1)) u_pipe_b (
            .clk(clk), .flush(!reset_n), .in_valid(rv_b_q), .in_data(ram_b_q),
            .out_valid(b_vld), .out_data(b_out)
        );
    end else begin : g_direct
        assign a_vld = rv_a_q;
        assign a_out = ram_a_q;
        assign b_vld = rv_b_q;
        assign b_out = ram_b_q;
    end

`ifdef MRAM_PARITY_EN
    logic a_bad, b_bad, perr_q;
    assign a_bad = a_vld && (^a_out);
    assign b_bad = b_vld && (^b_out);

    always_ff @(posedge clk) begin
        if (!reset_n || enter_clear) perr_q <= 1'b0;
        else if (a_bad || b_bad)     perr_q <= 1'b1;
    end

    assign parity_err = perr_q || a_bad || b_bad;
`else
    assign parity_err = 1'b0;
`endif

    assign busy       = (state_q == MRAM_CLEAR);
    assign collision  = coll_q;
    assign a_rd_valid = a_vld;
    assign b_rd_valid = b_vld;
    assign a_rd_data  = a_out[RAM_WIDTH-1:0];
    assign b_rd_data  = b_out[RAM_WIDTH-1:0];

endmodule

// File: tb/tb_mram_ctrl.sv
// tb_mram_ctrl: three DUTs (read latency 1/2/3) share directed stimulus; a queue
// scoreboard per DUT/port checks read data and exact valid timing.
module tb_mram_ctrl;

    localparam int W     = 72;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int N     = 3;

    typedef struct {
        logic [W-1:0] d;
        int           cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n, clear_req, pending_clear;
    logic          a_en, a_wr_en, b_en, b_wr_en;
    logic [AW-1:0] a_addr, b_addr;
    logic [W-1:0]  a_wr_data, b_wr_data;

    logic         busy [N];
    logic         collision [N];
    logic         parity_err [N];
    logic         a_rd_valid [N];
    logic         b_rd_valid [N];
    logic [W-1:0] a_rd_data [N];
    logic [W-1:0] b_rd_data [N];

    exp_t qa [N][$];
    exp_t qb [N][$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    int   n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < N; i++) begin : g_dut
        mram_ctrl #(
            .RAM_WIDTH(W), .DEPTH(DEPTH), .READ_LATENCY(i + 1), .CLEAR_ON_RESET(1)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .busy(busy[i]),
            .a_en(a_en), .a_wr_en(a_wr_en), .a_addr(a_addr), .a_wr_data(a_wr_data),
            .a_rd_data(a_rd_data[i]), .a_rd_valid(a_rd_valid[i]),
            .b_en(b_en), .b_wr_en(b_wr_en), .b_addr(b_addr), .b_wr_data(b_wr_data),
            .b_rd_data(b_rd_data[i]), .b_rd_valid(b_rd_valid[i]),
            .collision(collision[i]), .parity_err(parity_err[i])
        );
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid pops the oldest expected read for that DUT/port.
    task automatic mon(input int i, input int port, input logic [W-1:0] d);
        exp_t e;
        tests++;
        if ((port == 0 && qa[i].size() == 0) || (port == 1 && qb[i].size() == 0)) begin
            fails++;
            $display("FAIL rd_valid_unexpected lat%0d port%0d: got data %0h at cycle %0d, expected no valid",
                     i + 1, port, d, cyc);
            return;
        end
        if (port == 0) e = qa[i].pop_front();
        else           e = qb[i].pop_front();
        if (d !== e.d || cyc != e.cyc + i) begin
            fails++;
            $display("FAIL rd_data lat%0d port%0d: got %0h at cycle %0d, expected %0h at cycle %0d",
                     i + 1, port, d, cyc, e.d, e.cyc + i);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (a_rd_valid[i] === 1'b1) mon(i, 0, a_rd_data[i]);
            if (b_rd_valid[i] === 1'b1) mon(i, 1, b_rd_data[i]);
        end
    end

    task automatic drive(input logic ae, input logic awe, input int aa, input logic [W-1:0] ad,
                         input logic [W-1:0] ea, input logic be, input logic bwe, input int ba,
                         input logic [W-1:0] bd, input logic [W-1:0] eb, input logic accept);
        exp_t e;
        @(negedge clk);
        clear_req     = pending_clear;
        pending_clear = 1'b0;
        a_en = ae; a_wr_en = awe; a_addr = AW'(aa); a_wr_data = ad;
        b_en = be; b_wr_en = bwe; b_addr = AW'(ba); b_wr_data = bd;
        e.cyc = cyc + 1;
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                if (ae && !awe) begin e.d = ea; qa[i].push_back(e); end
                if (be && !bwe) begin e.d = eb; qb[i].push_back(e); end
            end
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 1);
    endtask
    task automatic wr_a(input int a, input logic [W-1:0] d); drive(1, 1, a, d, '0, 0, 0, 0, '0, '0, 1); endtask
    task automatic wr_b(input int a, input logic [W-1:0] d); drive(0, 0, 0, '0, '0, 1, 1, a, d, '0, 1); endtask
    task automatic rd_a(input int a, input logic [W-1:0] e); drive(1, 0, a, '0, e, 0, 0, 0, '0, '0, 1); endtask
    task automatic rd_b(input int a, input logic [W-1:0] e); drive(0, 0, 0, '0, '0, 1, 0, a, '0, e, 1); endtask

    // Counts cycles with busy high, starting at the current negedge; bounded.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (busy[0] === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; clear_req = 1'b0; pending_clear = 1'b0;
        a_en = 0; a_wr_en = 0; a_addr = '0; a_wr_data = '0;
        b_en = 0; b_wr_en = 0; b_addr = '0; b_wr_data = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("reset_busy lat%0d", i + 1), busy[i], 1);
            check($sformatf("reset_a_valid lat%0d", i + 1), a_rd_valid[i], 0);
            check($sformatf("reset_a_data lat%0d", i + 1), a_rd_data[i], 0);
            check($sformatf("reset_b_data lat%0d", i + 1), b_rd_data[i], 0);
            check($sformatf("reset_collision lat%0d", i + 1), collision[i], 0);
            check($sformatf("reset_parity lat%0d", i + 1), parity_err[i], 0);
        end
        reset_n = 1'b1;
        wait_ready(n);
        check("clear_on_reset_len", n, DEPTH);

        // Whole array reads zero after the reset clear; both ports streaming.
        for (int k = 0; k < DEPTH; k++) drive(1, 0, k, '0, '0, 1, 0, DEPTH - 1 - k, '0, '0, 1);
        idle(5);

        // Latency and back-to-back streaming.
        wr_a(3, 'hA5);
        rd_a(3, 'hA5);
        idle(4);
        for (int k = 0; k < 8; k++) wr_b(k, W'('h10 + k));
        for (int k = 0; k < 8; k++) rd_a(k, W'('h10 + k));
        idle(5);

        // Same-address write collision: A wins, flag sticky until clear.
        drive(1, 1, 5, 'h11, '0, 1, 1, 5, 'h22, '0, 1);
        idle(1);
        for (int i = 0; i < N; i++) check($sformatf("collision_set lat%0d", i + 1), collision[i], 1);
        rd_a(5, 'h11);
        rd_b(5, 'h11);
        idle(6);
        for (int i = 0; i < N; i++) check($sformatf("collision_sticky lat%0d", i + 1), collision[i], 1);
        pending_clear = 1'b1;
        idle(1);
        idle(1);
        for (int i = 0; i < N; i++) begin
            check($sformatf("clear_busy lat%0d", i + 1), busy[i], 1);
            check($sformatf("collision_cleared lat%0d", i + 1), collision[i], 0);
        end
        wait_ready(n);
        check("clear_req_len", n, DEPTH);
        rd_a(5, '0);
        idle(4);

        // Read on one port, write on the other, same address: old word returned.
        wr_b(7, 'h44);
        drive(1, 1, 7, 'h33, '0, 1, 0, 7, '0, 'h44, 1);
        rd_b(7, 'h33);
        idle(5);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rd_data_hold lat%0d", i + 1), b_rd_data[i], 'h33);
            check($sformatf("no_collision_rw lat%0d", i + 1), collision[i], 0);
        end

        // Traffic during clear is dropped; a read accepted with clear_req completes.
        wr_a(9, 'h99);
        pending_clear = 1'b1;
        rd_a(9, 'h99);
        idle(3);
        wr_a(0, 'h77);
        drive(1, 0, 1, '0, '0, 1, 0, 2, '0, '0, 0);
        drive(0, 0, 0, '0, '0, 1, 1, 4, 'h55, '0, 1);
        idle(1);
        wait_ready(n);
        rd_a(0, '0);
        rd_b(4, '0);
        rd_a(9, '0);
        idle(5);

        // Reset in the middle of a clear restarts it from address 0.
        pending_clear = 1'b1;
        idle(1);
        idle(5);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready(n);
        check("clear_restart_len", n, DEPTH);
        rd_a(3, '0);
        idle(4);

`ifdef MRAM_PARITY_EN
        wr_a(3, 'hA5);
        idle(1);
        g_dut[0].u_dut.mem[3][0] = ~g_dut[0].u_dut.mem[3][0];
        g_dut[1].u_dut.mem[3][0] = ~g_dut[1].u_dut.mem[3][0];
        g_dut[2].u_dut.mem[3][0] = ~g_dut[2].u_dut.mem[3][0];
        for (int i = 0; i < N; i++) check($sformatf("parity_before lat%0d", i + 1), parity_err[i], 0);
        rd_a(3, 'hA4);
        idle(5);
        for (int i = 0; i < N; i++) check($sformatf("parity_err_set lat%0d", i + 1), parity_err[i], 1);
`else
        wr_a(3, 'hA5);
        rd_a(3, 'hA5);
        idle(5);
        for (int i = 0; i < N; i++) check($sformatf("parity_tied_low lat%0d", i + 1), parity_err[i], 0);
`endif

        for (int i = 0; i < N; i++) begin
            check($sformatf("pending_a lat%0d", i + 1), qa[i].size(), 0);
            check($sformatf("pending_b lat%0d", i + 1), qb[i].size(), 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
